// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div_seq
//  Brief    : Iterative restoring divider for the EX stage. It takes one
//             quotient bit per cycle and stalls the pipeline until it is done.
//  Revision : 1.0 - initial release
// ============================================================================
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                div_start,
    input  logic                div_signed,
    input  logic                div_annul,
    input  logic [DATA_W-1:0]   div_op0,
    input  logic [DATA_W-1:0]   div_op1,
    output logic [2*DATA_W-1:0] div_result,
    output logic                div_ready,
    output logic                stall_req
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [2*DATA_W:0]   r_work, w_work_nxt;
    logic [DATA_W-1:0]   r_divisor, w_divisor_nxt;
    logic                r_neg_q, w_neg_q_nxt;
    logic                r_neg_r, w_neg_r_nxt;
    logic [2*DATA_W-1:0] r_result, w_result_nxt;
    logic                r_ready, w_ready_nxt;

    logic [DATA_W-1:0]   w_abs0, w_abs1;
    logic [2*DATA_W:0]   w_shift;
    logic [DATA_W+1:0]   w_diff;
    logic [DATA_W-1:0]   w_quo, w_rem;

    // Signed divides run on magnitudes; the signs are reapplied at the end.
    assign w_abs0 = (div_signed && div_op0[DATA_W-1]) ? -div_op0 : div_op0;
    assign w_abs1 = (div_signed && div_op1[DATA_W-1]) ? -div_op1 : div_op1;

    // One restoring step: shift, then trial subtract; a set MSB of the diff is a borrow.
    assign w_shift = r_work << 1;
    assign w_diff  = {1'b0, w_shift[2*DATA_W:DATA_W]} - {2'b00, r_divisor};

    assign w_quo = r_neg_q ? -r_work[DATA_W-1:0]        : r_work[DATA_W-1:0];
    assign w_rem = r_neg_r ? -r_work[2*DATA_W-1:DATA_W] : r_work[2*DATA_W-1:DATA_W];

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_work_nxt    = r_work;
        w_divisor_nxt = r_divisor;
        w_neg_q_nxt   = r_neg_q;
        w_neg_r_nxt   = r_neg_r;
        w_result_nxt  = r_result;
        w_ready_nxt   = r_ready;

        if (div_annul) begin
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = '0;
            w_result_nxt = '0;
            w_ready_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div_start) begin
                        w_work_nxt    = {{(DATA_W+1){1'b0}}, w_abs0};
                        w_divisor_nxt = w_abs1;
                        w_neg_q_nxt   = div_signed & (div_op0[DATA_W-1] ^ div_op1[DATA_W-1]);
                        w_neg_r_nxt   = div_signed & div_op0[DATA_W-1];
                        w_cnt_nxt     = '0;
                        w_state_nxt   = (div_op1 == '0) ? S_BYZERO : S_ON;
                    end
                end
                S_BYZERO: begin
                    w_state_nxt  = S_END;
                    w_result_nxt = '0;
                    w_ready_nxt  = 1'b1;
                end
                S_ON: begin
                    if (r_cnt == CNT_W'(DATA_W)) begin
                        w_state_nxt  = S_END;
                        w_result_nxt = {w_rem, w_quo};
                        w_ready_nxt  = 1'b1;
                    end else begin
                        if (!w_diff[DATA_W+1]) begin
                            w_work_nxt = {w_diff[DATA_W:0], w_shift[DATA_W-1:1], 1'b1};
                        end else begin
                            w_work_nxt = w_shift;
                        end
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_END: begin
                    if (!div_start) begin
                        w_state_nxt  = S_IDLE;
                        w_result_nxt = '0;
                        w_ready_nxt  = 1'b0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_work    <= w_work_nxt;
            r_divisor <= w_divisor_nxt;
            r_neg_q   <= w_neg_q_nxt;
            r_neg_r   <= w_neg_r_nxt;
            r_result  <= w_result_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign div_result = r_result;
    assign div_ready  = r_ready;
    assign stall_req  = div_start & ~r_ready & ~div_annul;

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_seq
//  Brief    : Self-checking bench for div_seq against an arithmetic reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq;

    logic        clk;
    logic        rst_;
    logic        div_start;
    logic        div_signed;
    logic        div_annul;
    logic [31:0] div_op0;
    logic [31:0] div_op1;
    logic [63:0] div_result;
    logic        div_ready;
    logic        stall_req;

    int n_vec;
    int n_err;

    div_seq #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_annul  (div_annul),
        .div_op0    (div_op0),
        .div_op1    (div_op1),
        .div_result (div_result),
        .div_ready  (div_ready),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division truncating toward zero, 0 for a zero divisor.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issues a request, scrambles operands after the start edge, waits for ready.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output logic [63:0] res, output int lat, output int stl);
        @(negedge clk);
        div_op0 = a; div_op1 = b; div_signed = sgn; div_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_op0 = $urandom; div_op1 = $urandom; div_signed = 1'($urandom_range(0, 1));
        lat = 0; stl = 0;
        while (div_ready !== 1'b1 && lat < 200) begin
            if (stall_req === 1'b1) stl++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        res = div_result;
    endtask

    // Drops the request (caller is at a negedge) and samples one edge later.
    task automatic end_div(output logic rdy, output logic [63:0] res);
        div_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rdy = div_ready;
        res = div_result;
    endtask

    task automatic test_reset;
        rst_ = 1'b0; div_start = 1'b0; div_signed = 1'b0; div_annul = 1'b0;
        div_op0 = '0; div_op1 = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (div_ready !== 1'b0 || div_result !== 64'd0 || stall_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset: ready=%b result=%h stall=%b, want 0/0/0", div_ready, div_result, stall_req);
        end
        rst_ = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned_basic;
        logic [63:0] res, res2; int lat, stl; logic rdy2;
        run_div(32'd100, 32'd7, 1'b0, res, lat, stl);
        n_vec++;
        if (res !== {32'd2, 32'd14}) begin
            n_err++; $display("FAIL u100_7 result: got %h want %h", res, {32'd2, 32'd14});
        end
        n_vec++;
        if (lat !== 33 || stl !== 33) begin
            n_err++; $display("FAIL u100_7 timing: lat=%0d stall=%0d want 33/33", lat, stl);
        end
        n_vec++;
        if (stall_req !== 1'b0) begin
            n_err++; $display("FAIL u100_7 release: stall=%b want 0", stall_req);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            n_vec++;
            if (div_ready !== 1'b1 || div_result !== {32'd2, 32'd14}) begin
                n_err++; $display("FAIL u100_7 hold: ready=%b result=%h want 1/%h", div_ready, div_result, {32'd2, 32'd14});
            end
        end
        end_div(rdy2, res2);
        n_vec++;
        if (rdy2 !== 1'b0 || res2 !== 64'd0) begin
            n_err++; $display("FAIL u100_7 clear: ready=%b result=%h want 0/0", rdy2, res2);
        end
    endtask

    task automatic test_signed;
        logic [31:0] a_tab [4] = '{32'hFFFF_FFF9, 32'd7,        32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] b_tab [4] = '{32'd2,        32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [63:0] e_tab [4] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd1, 32'hFFFF_FFFD},
                                   {32'hFFFF_FFFF, 32'd3},        {32'd0, 32'h8000_0000}};
        logic [63:0] res, res2; int lat, stl; logic rdy2;
        for (int i = 0; i < 4; i++) begin
            run_div(a_tab[i], b_tab[i], 1'b1, res, lat, stl);
            n_vec++;
            if (res !== e_tab[i] || lat !== 33) begin
                n_err++; $display("FAIL signed[%0d] %h/%h: got %h lat=%0d want %h lat=33", i, a_tab[i], b_tab[i], res, lat, e_tab[i]);
            end
            end_div(rdy2, res2);
        end
    endtask

    task automatic test_overflow_unsigned;
        logic [63:0] res, res2; int lat, stl; logic rdy2;
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, res, lat, stl);
        n_vec++;
        if (res !== {32'd0, 32'hFFFF_FFFF}) begin
            n_err++; $display("FAIL umax_1: got %h want %h", res, {32'd0, 32'hFFFF_FFFF});
        end
        end_div(rdy2, res2);
    endtask

    task automatic test_div_by_zero;
        logic [63:0] res, res2; int lat, stl; logic rdy2;
        for (int s = 0; s < 2; s++) begin
            run_div(32'h1234_5678, 32'd0, 1'(s), res, lat, stl);
            n_vec++;
            if (res !== 64'd0 || lat !== 1 || stl !== 1 || div_ready !== 1'b1) begin
                n_err++; $display("FAIL divzero s=%0d: result=%h lat=%0d stall=%0d ready=%b want 0/1/1/1", s, res, lat, stl, div_ready);
            end
            end_div(rdy2, res2);
        end
    endtask

    task automatic test_annul;
        logic [63:0] res, res2; int lat, stl; logic rdy2; int saw_ready;
        @(negedge clk);
        div_op0 = 32'd100; div_op1 = 32'd7; div_signed = 1'b0; div_start = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        div_annul = 1'b1;
        #1;
        n_vec++;
        if (stall_req !== 1'b0) begin
            n_err++; $display("FAIL annul stall: stall=%b want 0", stall_req);
        end
        @(posedge clk);
        @(negedge clk);
        div_annul = 1'b0; div_start = 1'b0;
        saw_ready = 0;
        for (int i = 0; i < 40; i++) begin
            if (div_ready !== 1'b0 || stall_req !== 1'b0) saw_ready++;
            @(posedge clk); @(negedge clk);
        end
        n_vec++;
        if (saw_ready !== 0) begin
            n_err++; $display("FAIL annul quiet: %0d cycles with ready/stall high, want 0", saw_ready);
        end
        run_div(32'd100, 32'd7, 1'b0, res, lat, stl);
        n_vec++;
        if (res !== {32'd2, 32'd14} || lat !== 33) begin
            n_err++; $display("FAIL annul restart: got %h lat=%0d want %h lat=33", res, lat, {32'd2, 32'd14});
        end
        end_div(rdy2, res2);
    endtask

    task automatic test_async_reset;
        logic [63:0] res, res2; int lat, stl; logic rdy2;
        @(negedge clk);
        div_op0 = 32'd1000; div_op1 = 32'd3; div_signed = 1'b0; div_start = 1'b1;
        repeat (20) @(posedge clk);
        #2 rst_ = 1'b0;
        #1;
        n_vec++;
        if (div_ready !== 1'b0 || div_result !== 64'd0) begin
            n_err++; $display("FAIL async mid: ready=%b result=%h want 0/0", div_ready, div_result);
        end
        @(negedge clk);
        div_start = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
        end
        n_vec++;
        if (div_ready !== 1'b0) begin
            n_err++; $display("FAIL async discard: ready=%b want 0", div_ready);
        end
        run_div(32'd100, 32'd7, 1'b0, res, lat, stl);
        n_vec++;
        if (res !== {32'd2, 32'd14} || lat !== 33 || stl !== 33) begin
            n_err++; $display("FAIL async restart: got %h lat=%0d stall=%0d want %h/33/33", res, lat, stl, {32'd2, 32'd14});
        end
        // Reset while a result is held must clear it before the next edge.
        #2 rst_ = 1'b0;
        #1;
        n_vec++;
        if (div_ready !== 1'b0 || div_result !== 64'd0) begin
            n_err++; $display("FAIL async end: ready=%b result=%h want 0/0", div_ready, div_result);
        end
        @(negedge clk);
        div_start = 1'b0;
        rst_ = 1'b1;
        @(negedge clk);
        end_div(rdy2, res2);
    endtask

    task automatic test_random;
        logic [63:0] res, res2, exp; int lat, stl; logic rdy2;
        logic [31:0] a, b; logic sgn; int sel;
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            a   = (sel == 9) ? 32'h8000_0000 : $urandom;
            if (sel == 0)      b = 32'd0;
            else if (sel < 4)  b = 32'($urandom_range(1, 15));
            else if (sel == 4) b = 32'hFFFF_FFFF;
            else               b = $urandom;
            sgn = 1'($urandom_range(0, 1));
            exp = model(a, b, sgn);
            run_div(a, b, sgn, res, lat, stl);
            n_vec++;
            if (res !== exp) begin
                n_err++; $display("FAIL rand[%0d] %h/%h s=%0d: got %h want %h", i, a, b, sgn, res, exp);
            end
            n_vec++;
            if (lat !== ((b == 32'd0) ? 1 : 33) || stl !== lat) begin
                n_err++; $display("FAIL rand[%0d] timing: lat=%0d stall=%0d want %0d", i, lat, stl, (b == 32'd0) ? 1 : 33);
            end
            end_div(rdy2, res2);
            n_vec++;
            if (rdy2 !== 1'b0 || res2 !== 64'd0) begin
                n_err++; $display("FAIL rand[%0d] clear: ready=%b result=%h want 0/0", i, rdy2, res2);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_overflow_unsigned();
        test_div_by_zero();
        test_annul();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative 32-bit divide sequencer for the EX stage.
- Latches operands on a start request and runs one restoring-division step per cycle.
- Raises a stall request so the pipeline holds EX while the divide runs.
- Returns {remainder, quotient} with a ready flag for EX to write into HI/LO.

Parameters:
DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
clk  input  1  system clock, rising edge
rst_  input  1  asynchronous active-low reset
div_start  input  1  divide request from EX; held high until div_ready is seen
div_signed  input  1  1 = signed divide, 0 = unsigned; sampled with div_start
div_annul  input  1  abort (flush or exception); overrides div_start
div_op0  input  32  dividend; sampled on the start edge
div_op1  input  32  divisor; sampled on the start edge
div_result  output  64  {remainder[63:32], quotient[31:0]}, registered
div_ready  output  1  result valid, registered
stall_req  output  1  combinational stall request to pipeline control

Behaviour:
- Reset: rst_=0 asynchronously forces state=IDLE, cnt=0, div_result=0, div_ready=0, all internal registers 0. Reset mid-divide discards the operation.
- States: IDLE, BYZERO, ON, END. Encoding is implementation choice.
- IDLE:
  - div_annul=1: stay IDLE.
  - div_start=1 and div_op1==0: go BYZERO.
  - div_start=1 and div_op1!=0: go ON, cnt=0.
  - Latching on the start edge: if div_signed=1, latch |op0| and |op1| as unsigned values and record neg_q = op0[31]^op1[31] and neg_r = op0[31]. Otherwise latch raw values with neg_q=neg_r=0.
- BYZERO: next edge goes END with div_result=0 and div_ready=1.
- ON:
  - Each edge with cnt<32 does one restoring step on a 65-bit work register {partial_rem, dividend}: shift left 1, trial-subtract the divisor. On no borrow, keep the difference and set the quotient bit to 1; otherwise set it to 0. Then cnt++.
  - Edge with cnt==32: go END. Register quotient and remainder, negating quotient if neg_q and remainder if neg_r (two's complement, mod 2^32). Set div_ready=1.
- Latency: the start-sampling edge is E0. The result and div_ready are visible after E33, so stall spans 33 cycles for a normal divide. For BYZERO they are visible after E1.
- END:
  - div_result and div_ready are held while div_start=1.
  - div_start=0: next edge goes IDLE, div_ready=0, div_result=0.
  - A new request needs at least one cycle with div_start=0 (back-to-back starts are not accepted from END).
- Annul: div_annul=1 in BYZERO, ON or END sends the next edge to IDLE with div_ready=0, div_result=0 and cnt=0. div_annul has priority over div_start in every state.
- stall_req = div_start & ~div_ready & ~div_annul (combinational). The pipeline therefore releases in the cycle div_ready rises.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (natural wrap). No trap is raised.
- Divisor 0 gives the all-zero result regardless of div_signed. No exception is raised.
- div_op0, div_op1 and div_signed changes after the start edge have no effect.

Test Plan:
- Unsigned 100/7, start held → stall_req high 33 cycles; div_ready after E33; div_result = {0x00000002, 0x0000000E}; result cleared one cycle after start drops.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/−2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero (op1=0) → div_ready after E1, div_result = 0, stall_req for 1 cycle.
- Overflow: signed 0x80000000/0xFFFFFFFF → {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF/0x00000001 → {0, 0xFFFFFFFF}.
- Annul pulse at E10 of a divide → IDLE at E11, stall_req low, div_ready never asserts. A fresh 100/7 start afterwards completes correctly.
- Assert rst_=0 asynchronously (between edges) at cycle 20 of a divide → outputs 0 immediately. After release, a new divide completes with correct result and 33-cycle latency.
